// File: rtl/debounce_array.sv
// debounce_array: a bank of independent debouncers for active-low push buttons.
// Each channel synchronises its raw input, requires CNT_NUM stable cycles before
// changing its debounced level, and emits registered press/release pulses.
// Long-press detection (hold counter and key_long pulse) is built only when the
// macro DEBOUNCE_LONG_PRESS_EN is defined; otherwise key_long is tied low.
`timescale 1ns/1ps
module debounce_array #(
    parameter int KEY_NUM  = 4,
    parameter int CNT_NUM  = 30,
    parameter int LONG_NUM = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_n,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int CW = $clog2(CNT_NUM);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_NUM - 1);

    // Reject parameter sets the counters cannot represent.
    if (KEY_NUM < 1 || KEY_NUM > 32 || CNT_NUM < 2 || LONG_NUM < 1) begin : g_bad_params
        $error("debounce_array: parameter out of range");
    end

    logic [KEY_NUM-1:0]         s1_q, s2_q;
    logic [KEY_NUM-1:0]         state_q, state_d;
    logic [KEY_NUM-1:0]         press_q, press_d;
    logic [KEY_NUM-1:0]         release_q, release_d;
    logic [KEY_NUM-1:0][CW-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser per channel; idles at the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= key_n;
            s2_q <= s1_q;
        end
    end

    // Stability window: a differing level must persist CNT_NUM cycles to be accepted.
    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (s2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_LAST) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i]     = '0;
                state_d[i]   = s2_q[i];
                press_d[i]   = ~s2_q[i];
                release_d[i] = s2_q[i];
            end
        end
    end

    // Debounced level and edge pulses update together so a pulse marks the first new-level cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            state_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_NUM + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_NUM);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_NUM - 1);

    logic [KEY_NUM-1:0][HW-1:0] hold_q, hold_d;
    logic [KEY_NUM-1:0]         long_q, long_d;

    // Hold counter saturates at LONG_NUM so the long pulse fires once per press; a release clears it.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (state_q[i] || release_d[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] != HOLD_MAX) begin
                hold_d[i] = hold_q[i] + 1'b1;
                long_d[i] = (hold_q[i] == HOLD_PRE);
            end
        end
    end

    // Register hold counts and long-press pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_debounce_array.sv
// Testbench for debounce_array (KEY_NUM=4, CNT_NUM=30, LONG_NUM=100, 10 ns clock).
// Expected pulse events are queued as stimulus is driven; a monitor queues observed
// pulse events and each scenario task pairs and compares them.
`timescale 1ns/1ps
module tb_debounce_array;

    localparam int CNT  = 30;
    localparam int LONG = 100;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  lng;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_state, key_press, key_release, key_long;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_ev;

    debounce_array #(
        .KEY_NUM (4),
        .CNT_NUM (CNT),
        .LONG_NUM(LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle that shows any pulse, tagged with the edge number that produced it.
    always @(negedge clk) begin
        if (rst_n && ((key_press | key_release | key_long) != 4'b0000)) begin
            mon_ev = {32'(cyc), key_press, key_release, key_long};
            obs_q.push_back(mon_ev);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        ev_t e, o;
        key_n = 4'hF;
        #1 rst_n = 1'b0;
        #200;
        tests++;
        if (key_state !== 4'hF) begin
            fails++;
            $display("[TB] FAIL reset_state: got %b, expected 1111", key_state);
        end
        tests++;
        if (key_press !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_press: got %b, expected 0000", key_press);
        end
        tests++;
        if (key_release !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_release: got %b, expected 0000", key_release);
        end
        tests++;
        if (key_long !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_long: got %b, expected 0000", key_long);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(60);
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            o = obs_q[0];
            $display("[TB] FAIL reset_no_pulse: got %0d events (first cyc=%0d p=%b r=%b l=%b), expected 0",
                     obs_q.size(), o.cyc, o.press, o.rel, o.lng);
        end
        obs_q.delete();
        exp_q.delete();
        e = '0;
    endtask

    task automatic test_bouncy_press();
        ev_t e, o;
        int  e0, e1;
        e0 = 0;
        for (int t = 0; t < 5; t++) begin
            key_n[0] = ~key_n[0];
            e0 = cyc + 1;
            wait_cycles(5);
        end
        e = {32'(e0 + CNT + 1), 4'b0001, 4'b0000, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT);
        tests++;
        if (key_state !== 4'b1110) begin
            fails++;
            $display("[TB] FAIL bouncy_state: got %b, expected 1110", key_state);
        end
        key_n[0] = 1'b1;
        e1 = cyc + 1;
        e = {32'(e1 + CNT + 1), 4'b0000, 4'b0001, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 10);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            tests++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); fails++;
                $display("[TB] FAIL bouncy_event: got none, expected cyc=%0d p=%b r=%b l=%b", e.cyc, e.press, e.rel, e.lng);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); fails++;
                $display("[TB] FAIL bouncy_event: got cyc=%0d p=%b r=%b l=%b, expected none", o.cyc, o.press, o.rel, o.lng);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL bouncy_event: got cyc=%0d p=%b r=%b l=%b, expected cyc=%0d p=%b r=%b l=%b",
                             o.cyc, o.press, o.rel, o.lng, e.cyc, e.press, e.rel, e.lng);
                end
            end
        end
    endtask

    task automatic test_glitch();
        ev_t o;
        key_n[2] = 1'b0;
        wait_cycles(20);
        key_n[2] = 1'b1;
        wait_cycles(CNT + 10);
        tests++;
        if (key_state !== 4'hF) begin
            fails++;
            $display("[TB] FAIL glitch_state: got %b, expected 1111", key_state);
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            o = obs_q[0];
            $display("[TB] FAIL glitch_no_pulse: got %0d events (first cyc=%0d p=%b r=%b l=%b), expected 0",
                     obs_q.size(), o.cyc, o.press, o.rel, o.lng);
        end
        obs_q.delete();
    endtask

    task automatic test_long_press();
        ev_t e, o;
        int  e0, e1, p;
        key_n[1] = 1'b0;
        e0 = cyc + 1;
        p  = e0 + CNT + 1;
        e = {32'(p), 4'b0010, 4'b0000, 4'b0000};
        exp_q.push_back(e);
`ifdef DEBOUNCE_LONG_PRESS_EN
        e = {32'(p + LONG), 4'b0000, 4'b0000, 4'b0010};
        exp_q.push_back(e);
`endif
        wait_cycles(CNT + 1 + 150);
        key_n[1] = 1'b1;
        wait_cycles(3);
        key_n[1] = 1'b0;
        wait_cycles(3);
        key_n[1] = 1'b1;
        e1 = cyc + 1;
        e = {32'(e1 + CNT + 1), 4'b0000, 4'b0010, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 30);
        tests++;
        if (key_state !== 4'hF) begin
            fails++;
            $display("[TB] FAIL long_state: got %b, expected 1111", key_state);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            tests++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); fails++;
                $display("[TB] FAIL long_event: got none, expected cyc=%0d p=%b r=%b l=%b", e.cyc, e.press, e.rel, e.lng);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); fails++;
                $display("[TB] FAIL long_event: got cyc=%0d p=%b r=%b l=%b, expected none", o.cyc, o.press, o.rel, o.lng);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL long_event: got cyc=%0d p=%b r=%b l=%b, expected cyc=%0d p=%b r=%b l=%b",
                             o.cyc, o.press, o.rel, o.lng, e.cyc, e.press, e.rel, e.lng);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        int  e0, e1;
        key_n = 4'b0110;
        e0 = cyc + 1;
        e = {32'(e0 + CNT + 1), 4'b1001, 4'b0000, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 10);
        key_n = 4'hF;
        e1 = cyc + 1;
        e = {32'(e1 + CNT + 1), 4'b0000, 4'b1001, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 10);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            tests++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); fails++;
                $display("[TB] FAIL simul_event: got none, expected cyc=%0d p=%b r=%b l=%b", e.cyc, e.press, e.rel, e.lng);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); fails++;
                $display("[TB] FAIL simul_event: got cyc=%0d p=%b r=%b l=%b, expected none", o.cyc, o.press, o.rel, o.lng);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL simul_event: got cyc=%0d p=%b r=%b l=%b, expected cyc=%0d p=%b r=%b l=%b",
                             o.cyc, o.press, o.rel, o.lng, e.cyc, e.press, e.rel, e.lng);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        ev_t e, o;
        int  e0, e2, e3;
        key_n[3] = 1'b0;
        e0 = cyc + 1;
        e = {32'(e0 + CNT + 1), 4'b1000, 4'b0000, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 5);
        key_n[0] = 1'b0;
        wait_cycles(17);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (key_state !== 4'hF) begin
            fails++;
            $display("[TB] FAIL midrst_state: got %b, expected 1111", key_state);
        end
        tests++;
        if ((key_press | key_release | key_long) !== 4'h0) begin
            fails++;
            $display("[TB] FAIL midrst_pulses: got p=%b r=%b l=%b, expected all 0000", key_press, key_release, key_long);
        end
        @(negedge clk);
        wait_cycles(3);
        rst_n = 1'b1;
        e2 = cyc + 1;
        e = {32'(e2 + CNT + 1), 4'b1001, 4'b0000, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 8);
        tests++;
        if (key_state !== 4'b0110) begin
            fails++;
            $display("[TB] FAIL midrst_repress_state: got %b, expected 0110", key_state);
        end
        key_n = 4'hF;
        e3 = cyc + 1;
        e = {32'(e3 + CNT + 1), 4'b0000, 4'b1001, 4'b0000};
        exp_q.push_back(e);
        wait_cycles(CNT + 10);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            tests++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); fails++;
                $display("[TB] FAIL midrst_event: got none, expected cyc=%0d p=%b r=%b l=%b", e.cyc, e.press, e.rel, e.lng);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); fails++;
                $display("[TB] FAIL midrst_event: got cyc=%0d p=%b r=%b l=%b, expected none", o.cyc, o.press, o.rel, o.lng);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("[TB] FAIL midrst_event: got cyc=%0d p=%b r=%b l=%b, expected cyc=%0d p=%b r=%b l=%b",
                             o.cyc, o.press, o.rel, o.lng, e.cyc, e.press, e.rel, e.lng);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bouncy_press();
        test_glitch();
        test_long_press();
        test_simultaneous();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
